// File: rtl/button_conditioner.sv
// Push-button front end: per channel a 2-flop synchronizer, a counter debouncer
// and a press/hold FSM producing clean level, press/release and auto-repeat pulses.
module button_conditioner #(
  parameter int                     NUM_INPUTS      = 4,
  parameter int                     COUNT_WIDTH     = 29,
  parameter logic [COUNT_WIDTH-1:0] DEBOUNCE_CYCLES = COUNT_WIDTH'(1_000_000),
  parameter logic [COUNT_WIDTH-1:0] REPEAT_DELAY    = COUNT_WIDTH'(50_000_000),
  parameter logic [COUNT_WIDTH-1:0] REPEAT_PERIOD   = COUNT_WIDTH'(10_000_000),
  parameter bit                     REPEAT_EN       = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_INPUTS-1:0] btn_raw,
  output logic [NUM_INPUTS-1:0] btn_level,
  output logic [NUM_INPUTS-1:0] btn_press,
  output logic [NUM_INPUTS-1:0] btn_release,
  output logic [NUM_INPUTS-1:0] btn_repeat
);

  localparam logic [COUNT_WIDTH-1:0] ONE     = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] DB_LAST = DEBOUNCE_CYCLES - ONE;
  localparam logic [COUNT_WIDTH-1:0] RD_LAST = REPEAT_DELAY - ONE;
  localparam logic [COUNT_WIDTH-1:0] RP_LAST = REPEAT_PERIOD - ONE;

  typedef enum logic [1:0] {
    S_RELEASED,
    S_HOLD_WAIT,
    S_REPEATING
  } hold_state_e;

  logic [NUM_INPUTS-1:0] r_sync1;
  logic [NUM_INPUTS-1:0] r_sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      // NOTE: non-blocking so r_sync2 takes the old r_sync1, giving two real flop stages.
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_chan
    logic [COUNT_WIDTH-1:0] r_db_cnt;
    logic [COUNT_WIDTH-1:0] r_hold_cnt;
    hold_state_e            r_state;
    logic                   r_level;
    logic                   r_press;
    logic                   r_release;
    logic                   r_repeat;
    logic                   w_differ;
    logic                   w_accept;
    logic                   w_rise;
    logic                   w_fall;

    assign w_differ = r_sync2[g] ^ r_level;
    assign w_accept = w_differ && (r_db_cnt == DB_LAST);
    assign w_rise   = w_accept && !r_level;
    assign w_fall   = w_accept && r_level;

    // Any cycle where the input agrees with the accepted level restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_db_cnt  <= '0;
        r_level   <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        r_press   <= w_rise;
        r_release <= w_fall;
        if (!w_differ) begin
          r_db_cnt <= '0;
        end else if (w_accept) begin
          r_db_cnt <= '0;
          r_level  <= ~r_level;
        end else begin
          r_db_cnt <= r_db_cnt + ONE;
        end
      end
    end

    // A falling level overrides everything, so a release never carries a repeat.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state    <= S_RELEASED;
        r_hold_cnt <= '0;
        r_repeat   <= 1'b0;
      end else begin
        r_repeat <= 1'b0;
        if (!REPEAT_EN || w_fall) begin
          r_state    <= S_RELEASED;
          r_hold_cnt <= '0;
        end else begin
          case (r_state)
            S_RELEASED: begin
              if (w_rise) begin
                r_state    <= S_HOLD_WAIT;
                r_hold_cnt <= '0;
              end
            end
            S_HOLD_WAIT: begin
              if (r_hold_cnt == RD_LAST) begin
                r_repeat   <= 1'b1;
                r_hold_cnt <= '0;
                r_state    <= S_REPEATING;
              end else begin
                r_hold_cnt <= r_hold_cnt + ONE;
              end
            end
            S_REPEATING: begin
              if (r_hold_cnt == RP_LAST) begin
                r_repeat   <= 1'b1;
                r_hold_cnt <= '0;
              end else begin
                r_hold_cnt <= r_hold_cnt + ONE;
              end
            end
            default: begin
              r_state    <= S_RELEASED;
              r_hold_cnt <= '0;
            end
          endcase
        end
      end
    end

    assign btn_level[g]   = r_level;
    assign btn_press[g]   = r_press;
    assign btn_release[g] = r_release;
    assign btn_repeat[g]  = r_repeat;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: three parameter sets driven by one button bus,
// a window-based reference model checked every cycle, plus directed corner cases.
module tb_button_conditioner;

  localparam int NDUT = 3;
  localparam int M_DC [NDUT] = '{8, 8, 1};
  localparam int M_RD [NDUT] = '{20, 20, 1};
  localparam int M_RP [NDUT] = '{5, 5, 1};
  localparam int M_EN [NDUT] = '{1, 0, 1};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn_raw = 4'b0000;
  logic [3:0] lvl [NDUT];
  logic [3:0] prs [NDUT];
  logic [3:0] rel [NDUT];
  logic [3:0] rpt [NDUT];

  always #5 clk = ~clk;

  button_conditioner #(.NUM_INPUTS(4), .COUNT_WIDTH(29), .DEBOUNCE_CYCLES(29'd8),
    .REPEAT_DELAY(29'd20), .REPEAT_PERIOD(29'd5), .REPEAT_EN(1'b1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .btn_level(lvl[0]),
    .btn_press(prs[0]), .btn_release(rel[0]), .btn_repeat(rpt[0]));

  button_conditioner #(.NUM_INPUTS(4), .COUNT_WIDTH(29), .DEBOUNCE_CYCLES(29'd8),
    .REPEAT_DELAY(29'd20), .REPEAT_PERIOD(29'd5), .REPEAT_EN(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .btn_level(lvl[1]),
    .btn_press(prs[1]), .btn_release(rel[1]), .btn_repeat(rpt[1]));

  button_conditioner #(.NUM_INPUTS(4), .COUNT_WIDTH(29), .DEBOUNCE_CYCLES(29'd1),
    .REPEAT_DELAY(29'd1), .REPEAT_PERIOD(29'd1), .REPEAT_EN(1'b1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .btn_level(lvl[2]),
    .btn_press(prs[2]), .btn_release(rel[2]), .btn_repeat(rpt[2]));

  // Reference model: raw sample history per channel; the level flips when the last
  // DEBOUNCE samples seen through the 2-stage synchronizer all disagree with it.
  logic [15:0] m_hist  [NDUT][4];
  logic        m_level [NDUT][4];
  int          m_rise  [NDUT][4];
  int          m_t;
  logic [3:0]  e_lvl [NDUT];
  logic [3:0]  e_prs [NDUT];
  logic [3:0]  e_rel [NDUT];
  logic [3:0]  e_rpt [NDUT];

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string      name;
    logic [3:0] raw;
    int         ticks;
    logic [3:0] exp_lvl;
    logic [3:0] exp_prs;
    logic [3:0] exp_rel;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NDUT; i++) begin
      for (int c = 0; c < 4; c++) begin
        m_hist[i][c]  = '0;
        m_level[i][c] = 1'b0;
        m_rise[i][c]  = 0;
      end
      e_lvl[i] = '0;
      e_prs[i] = '0;
      e_rel[i] = '0;
      e_rpt[i] = '0;
    end
  endtask

  task automatic model_step();
    bit all_diff;
    int d;
    m_t++;
    for (int i = 0; i < NDUT; i++) begin
      e_prs[i] = '0;
      e_rel[i] = '0;
      e_rpt[i] = '0;
      for (int c = 0; c < 4; c++) begin
        m_hist[i][c] = {m_hist[i][c][14:0], btn_raw[c]};
        all_diff = 1'b1;
        for (int j = 2; j <= M_DC[i] + 1; j++)
          if (m_hist[i][c][j] == m_level[i][c]) all_diff = 1'b0;
        if (all_diff) begin
          m_level[i][c] = ~m_level[i][c];
          if (m_level[i][c]) begin
            e_prs[i][c]  = 1'b1;
            m_rise[i][c] = m_t;
          end else begin
            e_rel[i][c] = 1'b1;
          end
        end else if (m_level[i][c] && M_EN[i] != 0) begin
          d = m_t - m_rise[i][c];
          if (d >= M_RD[i] && ((d - M_RD[i]) % M_RP[i]) == 0) e_rpt[i][c] = 1'b1;
        end
        e_lvl[i][c] = m_level[i][c];
      end
    end
  endtask

  // Inputs change on the falling edge; outputs are compared there too.
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    for (int i = 0; i < NDUT; i++)
      check($sformatf("dut%0d_cyc%0d", i, m_t), {lvl[i], prs[i], rel[i], rpt[i]},
            {e_lvl[i], e_prs[i], e_rel[i], e_rpt[i]});
  endtask

  task automatic do_reset();
    btn_raw = 4'b0000;
    rst_n   = 1'b0;
    model_clear();
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  // Edges from the first sampling edge until the pulse shows; -1 if the budget expires.
  task automatic wait_pulse(input int inst, input bit is_rel, input int ch,
                            input int budget, output int edges);
    edges = -1;
    for (int n = 1; n <= budget; n++) begin
      tick();
      if ((is_rel ? rel[inst][ch] : prs[inst][ch]) == 1'b1) begin
        edges = n - 1;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int cnt;
    int cnt2;
    int total;
    int seg;
    int hold;
    bit hi;

    tbl[0] = '{"press_ch0",     4'b0001, 12, 4'b0001, 4'b0000, 4'b0000};
    tbl[1] = '{"short_ch1",     4'b0011,  5, 4'b0001, 4'b0000, 4'b0000};
    tbl[2] = '{"gap_ch1",       4'b0001,  3, 4'b0001, 4'b0000, 4'b0000};
    tbl[3] = '{"one_short_ch1", 4'b0011,  9, 4'b0001, 4'b0000, 4'b0000};
    tbl[4] = '{"accept_ch1",    4'b0011,  1, 4'b0011, 4'b0010, 4'b0000};
    tbl[5] = '{"release_both",  4'b0000, 10, 4'b0000, 4'b0000, 4'b0011};

    m_t = 0;
    model_clear();

    // Reset held while the buttons toggle.
    for (int k = 0; k < 5; k++) begin
      btn_raw = 4'($urandom);
      tick();
      check("reset_quiet", {lvl[0], prs[0], rel[0], rpt[0]}, 16'h0000);
    end

    // Reset released mid-debounce restarts the count.
    btn_raw = 4'b0001;
    rst_n   = 1'b1;
    repeat (4) tick();
    rst_n = 1'b0;
    model_clear();
    tick();
    rst_n = 1'b1;
    wait_pulse(0, 1'b0, 0, 40, n);
    check("rst_restart_lat", n, 9);
    check("press_level", lvl[0][0], 1'b1);
    tick();
    check("press_width", prs[0][0], 1'b0);
    btn_raw[0] = 1'b0;
    wait_pulse(0, 1'b1, 0, 40, n);
    check("release_lat", n, 9);

    // Single-cycle debounce: level follows two edges after sampling, repeat one edge later.
    do_reset();
    btn_raw = 4'b0001;
    wait_pulse(2, 1'b0, 0, 10, n);
    check("db1_lat", n, 2);
    tick();
    check("db1_first_repeat", rpt[2][0], 1'b1);

    // Table of level/press/release checkpoints.
    do_reset();
    foreach (tbl[v]) begin
      btn_raw = tbl[v].raw;
      repeat (tbl[v].ticks) tick();
      check({tbl[v].name, "_lvl"}, lvl[0], tbl[v].exp_lvl);
      check({tbl[v].name, "_prs"}, prs[0], tbl[v].exp_prs);
      check({tbl[v].name, "_rel"}, rel[0], tbl[v].exp_rel);
    end

    // Bounce on channel 1, ending on a low segment, then a settled press.
    do_reset();
    cnt = 0;
    total = 0;
    hi = 1'b1;
    while (total < 100 || hi == 1'b0) begin
      seg = $urandom_range(1, 7);
      btn_raw[1] = hi;
      for (int k = 0; k < seg; k++) begin
        tick();
        if (lvl[0][1] || prs[0][1] || rel[0][1]) cnt++;
      end
      total += seg;
      hi = ~hi;
    end
    check("bounce_quiet", cnt, 0);
    btn_raw[1] = 1'b1;
    wait_pulse(0, 1'b0, 1, 40, n);
    check("bounce_settle_lat", n, 9);
    cnt = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (prs[0][1]) cnt++;
    end
    check("bounce_one_press", cnt, 0);

    // Auto-repeat on channel 2.
    do_reset();
    btn_raw = 4'b0100;
    wait_pulse(0, 1'b0, 2, 40, n);
    check("rep_press_lat", n, 9);
    cnt = 0;
    for (int off = 1; off <= 49; off++) begin
      tick();
      if (rpt[0][2]) begin
        check($sformatf("rep_offset%0d", cnt), off, 20 + 5 * cnt);
        cnt++;
      end
    end
    check("rep_count", cnt, 6);
    btn_raw[2] = 1'b0;
    wait_pulse(0, 1'b1, 2, 40, n);
    check("rep_release_lat", n, 9);
    cnt = 0;
    cnt2 = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (rpt[0][2]) cnt++;
      if (rel[0][2]) cnt2++;
    end
    check("rep_after_release", cnt, 0);
    check("rep_single_release", cnt2, 0);

    // Release during HOLD_WAIT; the release lands exactly on the would-be first repeat.
    do_reset();
    btn_raw = 4'b1000;
    wait_pulse(0, 1'b0, 3, 40, n);
    cnt = 0;
    repeat (10) begin
      tick();
      if (rpt[0][3]) cnt++;
    end
    btn_raw[3] = 1'b0;
    n = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (rpt[0][3]) cnt++;
      if (rel[0][3]) begin
        n = k - 1;
        break;
      end
    end
    check("hw_release_lat", n, 9);
    repeat (25) begin
      tick();
      if (rpt[0][3]) cnt++;
    end
    check("hw_no_repeat", cnt, 0);

    // All channels together with repeat disabled.
    do_reset();
    btn_raw = 4'b1111;
    n = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (prs[1] != 4'b0000) begin
        n = k - 1;
        break;
      end
    end
    check("simul_lat", n, 9);
    check("simul_press", prs[1], 4'b1111);
    cnt = 0;
    repeat (60) begin
      tick();
      if (rpt[1] != 4'b0000) cnt++;
    end
    check("simul_no_repeat", cnt, 0);

    // Random hold lengths, occasional reset; the model checks every cycle.
    do_reset();
    for (int s = 0; s < 300; s++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      btn_raw = 4'($urandom);
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(15, 40) : $urandom_range(1, 10);
      repeat (hold) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
